// File: rtl/riscv_pkg.sv
// Shared types and helpers for the memory-access stage: access size and
// LSU state encodings, plus the alignment, byte-enable and store-data rules
// used when a request is latched.
package riscv_pkg;

  typedef enum logic [1:0] {
    MS_BYTE = 2'b00,
    MS_HALF = 2'b01,
    MS_WORD = 2'b10,
    MS_RSVD = 2'b11   // reserved encoding, behaves as a word access
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RSP,
    ST_DONE
  } lsu_state_t;

  // A byte is always aligned; a half needs addr[0]=0; word/reserved need addr[1:0]=0.
  function automatic logic is_aligned(input mem_size_t size, input logic [1:0] lo);
    case (size)
      MS_BYTE: is_aligned = 1'b1;
      MS_HALF: is_aligned = ~lo[0];
      default: is_aligned = (lo == 2'b00);
    endcase
  endfunction

  // Byte lanes touched by the access within the addressed word.
  function automatic logic [3:0] gen_be(input mem_size_t size, input logic [1:0] lo);
    case (size)
      MS_BYTE: gen_be = 4'b0001 << lo;
      MS_HALF: gen_be = 4'b0011 << {lo[1], 1'b0};
      default: gen_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated across lanes so the slave only needs the enables.
  function automatic logic [31:0] gen_wdata(input mem_size_t size, input logic [31:0] sd);
    case (size)
      MS_BYTE: gen_wdata = {4{sd[7:0]}};
      MS_HALF: gen_wdata = {2{sd[15:0]}};
      default: gen_wdata = sd;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-bus connection between the load/store unit (master) and the data RAM /
// UART MMIO decode (slave): a valid/ready request channel plus a read response.
interface load_store_unit_if;

  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ready, bus_rvalid, bus_rdata
  );

endinterface

// File: rtl/lsu_load_align.sv
// Load alignment: picks the addressed byte/half out of the returned word and
// sign- or zero-extends it; word loads pass straight through.
module lsu_load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  mem_size_t   size,
  input  logic        sign,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane extract and extension.
  always_comb begin
    // NOTE: every combinational output gets a value before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    data      = rdata;
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = rdata[{addr_lo[1], 4'b0000} +: 16];
    case (size)
      MS_BYTE: data = {{24{sign & byte_lane[7]}}, byte_lane};
      MS_HALF: data = {{16{sign & half_lane[15]}}, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: turns the decoder's load/store request and the ALU
// address into one bus transaction, stalls the core while it is in flight,
// and returns the aligned, extended load value in the cycle stall drops.
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255  // cycles in REQ/WAIT_RSP before abort; 0 disables
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_size,
  input  logic              mem_sign,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              stall,
  output logic              misaligned,
  output logic              bus_err,
  load_store_unit_if.master bus
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT);

  lsu_state_t       state, state_next;
  mem_size_t        size_in, size_q;
  logic             sign_q;
  logic [1:0]       addr_lo_q;
  logic [CNT_W-1:0] tmo_cnt;
  logic [31:0]      aligned_load;
  logic             op, aligned, tmo_expired;
  logic             start, rsp_take, tmo_hit;

  assign op          = mem_read | mem_write;
  assign size_in     = mem_size_t'(mem_size);
  assign aligned     = is_aligned(size_in, addr[1:0]);
  assign tmo_expired = (TIMEOUT != 0) && (tmo_cnt == TMO_MAX);

  lsu_load_align u_align (
    .rdata   (bus.bus_rdata),
    .addr_lo (addr_lo_q),
    .size    (size_q),
    .sign    (sign_q),
    .data    (aligned_load)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state decode plus the core-facing stall/misaligned flags.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    rsp_take   = 1'b0;
    tmo_hit    = 1'b0;
    stall      = 1'b0;
    misaligned = 1'b0;
    case (state)
      ST_IDLE: begin
        if (op) begin
          if (aligned) begin
            start      = 1'b1;
            stall      = 1'b1;
            state_next = ST_REQ;
          end else begin
            misaligned = 1'b1;
          end
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        if (bus.bus_ready) begin
          state_next = bus.bus_we ? ST_DONE : ST_WAIT_RSP;
        end else if (tmo_expired) begin
          tmo_hit    = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_WAIT_RSP: begin
        stall = 1'b1;
        if (bus.bus_rvalid) begin
          rsp_take   = 1'b1;
          state_next = ST_DONE;
        end else if (tmo_expired) begin
          tmo_hit    = 1'b1;
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;  // ST_DONE: one unstalled cycle
    endcase
  end

  // Request latches, bus drive, timeout counter and load result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.bus_valid <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
      size_q        <= MS_BYTE;
      sign_q        <= 1'b0;
      addr_lo_q     <= '0;
      tmo_cnt       <= '0;
      load_data     <= '0;
      bus_err       <= 1'b0;
    end else begin
      // Valid is high exactly for the cycles spent in REQ.
      bus.bus_valid <= (state_next == ST_REQ);
      // Aborts always land in DONE, so the flag lives for that one cycle.
      bus_err       <= tmo_hit;

      if (start) begin
        bus.bus_we    <= mem_write;
        bus.bus_addr  <= {addr[31:2], 2'b00};
        bus.bus_be    <= gen_be(size_in, addr[1:0]);
        bus.bus_wdata <= gen_wdata(size_in, store_data);
        size_q        <= size_in;
        sign_q        <= mem_sign;
        addr_lo_q     <= addr[1:0];
      end

      // Saturates at TIMEOUT; stays at zero when the timeout is disabled.
      if (start) begin
        tmo_cnt <= '0;
      end else if ((state == ST_REQ || state == ST_WAIT_RSP) && (TIMEOUT != 0) && !tmo_expired) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (rsp_take)     load_data <= aligned_load;
      else if (tmo_hit) load_data <= '0;
    end
  end

endmodule
